// File: rtl/mult_div_unit.sv
// Multicycle signed MULT/DIV unit: radix-2 shift-add multiply and restoring divide on
// operand magnitudes, one iteration per clock, results held in HI/LO registers.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        counter;
  logic                 op_r, sa, sb, dz;
  logic [WIDTH-1:0]     mcand, acc_hi, acc_lo;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [WIDTH:0]       mul_sum, rem_sh, trial;
  logic                 div_ge;
  logic [2*WIDTH-1:0]   prod_neg;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (op && (b == '0)) ? FINISH : RUN;
      RUN:     if (counter == '0) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // rem < |b| <= 2^(WIDTH-1), so the shifted remainder fits and trial[WIDTH] is the borrow.
  always_comb begin
    mag_a    = a[WIDTH-1] ? -a : a;
    mag_b    = b[WIDTH-1] ? -b : b;
    mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
    rem_sh   = {acc_hi, acc_lo[WIDTH-1]};
    trial    = rem_sh - {1'b0, mcand};
    div_ge   = ~trial[WIDTH];
    prod_neg = -{acc_hi, acc_lo};
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      counter  <= '0;
      op_r     <= 1'b0;
      sa       <= 1'b0;
      sb       <= 1'b0;
      dz       <= 1'b0;
      mcand    <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: if (start) begin
          op_r    <= op;
          sa      <= a[WIDTH-1];
          sb      <= b[WIDTH-1];
          dz      <= op && (b == '0);
          acc_hi  <= '0;
          counter <= CW'(WIDTH - 1);
          // MULT: multiplicand |a|, multiplier |b| in LO. DIV: divisor |b|, dividend |a| in LO.
          mcand   <= op ? mag_b : mag_a;
          acc_lo  <= op ? mag_a : mag_b;
        end
        RUN: begin
          if (op_r) begin
            acc_hi <= div_ge ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
          end else begin
            acc_hi <= mul_sum[WIDTH:1];
            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          end
          if (counter != '0) counter <= counter - CW'(1);
        end
        FINISH: begin
          done <= 1'b1;
          if (dz) begin
            div_zero <= 1'b1;
          end else if (op_r) begin
            lo <= (sa ^ sb) ? -acc_lo : acc_lo;
            hi <= sa ? -acc_hi : acc_hi;
          end else begin
            {hi, lo} <= (sa ^ sb) ? prod_neg : {acc_hi, acc_lo};
          end
        end
        default: ;
      endcase
    end
  end

endmodule
